// File: rtl/vga_timing_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Purpose  : Default 640x480@60 timing constants and the fetch FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_clk_div   = 2;

    localparam int c_h_display = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;

    localparam int c_v_display = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;

    localparam int c_h_total   = c_h_display + c_h_front + c_h_sync + c_h_back;
    localparam int c_v_total   = c_v_display + c_v_front + c_v_sync + c_v_back;

    localparam int c_coord_w   = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_controller_if.sv
`default_nettype none
// ============================================================================
// Interface: vga_timing_controller_if
// Purpose  : Line-fetch req/ack handshake between the timing controller
//            (master) and the framebuffer/line-buffer client (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_controller_if;

    logic                           fetch_req;
    logic [vga_pkg::c_coord_w-1:0]  fetch_line;
    logic                           fetch_ack;

    modport master (
        output fetch_req,
        output fetch_line,
        input  fetch_ack
    );

    modport slave (
        input  fetch_req,
        input  fetch_line,
        output fetch_ack
    );

endinterface
`default_nettype wire

// File: rtl/vga_timing_controller_axis.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : Wrapping raster counter for one axis with sync decode, a wrap
//            (carry) pulse and the display decode of the next count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter int WIDTH   = 10
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_en,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_carry,
    output logic                  o_display_next,
    output logic                  o_sync_n
);

    localparam int               c_total      = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [WIDTH-1:0] c_last       = WIDTH'(c_total - 1);
    localparam logic [WIDTH-1:0] c_display    = WIDTH'(DISPLAY);
    localparam logic [WIDTH-1:0] c_sync_first = WIDTH'(DISPLAY + FRONT);
    localparam logic [WIDTH-1:0] c_sync_last  = WIDTH'(DISPLAY + FRONT + SYNC - 1);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_sync_n;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;

    always_comb begin
        w_carry = i_en && (r_count == c_last);
        if (w_carry) begin
            w_next = '0;
        end else if (i_en) begin
            w_next = r_count + c_one;
        end else begin
            w_next = r_count;
        end
    end

    // Decode from the next count so the flags line up with the registered count.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count  <= '0;
            r_sync_n <= 1'b1;
        end else begin
            r_count  <= w_next;
            r_sync_n <= !((w_next >= c_sync_first) && (w_next <= c_sync_last));
        end
    end

    assign o_count        = r_count;
    assign o_carry        = w_carry;
    assign o_display_next = (w_next < c_display);
    assign o_sync_n       = r_sync_n;

endmodule
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_controller
// Purpose  : VGA raster timing (pixel divider, h/v counters, sync/blank decode)
//            and the per-line fetch request scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = c_clk_div,
    parameter int H_DISPLAY = c_h_display,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_DISPLAY = c_v_display,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               enable,
    output logic                    pixel_tick,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    display_on,
    output logic [c_coord_w-1:0]    pixel_x,
    output logic [c_coord_w-1:0]    pixel_y,
    output logic                    new_line,
    output logic                    frame_start,
    vga_timing_controller_if.master fetch,
    output logic                    underrun,
    output logic                    underrun_sticky
);

    localparam int                   c_div_w     = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0]   c_div_one   = c_div_w'(1);
    localparam logic [c_coord_w-1:0] c_fetch_x   = c_coord_w'(H_DISPLAY - 1);
    localparam logic [c_coord_w-1:0] c_v_last    = c_coord_w'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [c_coord_w-1:0] c_v_visible = c_coord_w'(V_DISPLAY);
    localparam logic [c_coord_w-1:0] c_coord_one = c_coord_w'(1);

    logic                 w_hold;
    logic                 w_clear;
    logic [c_div_w-1:0]   r_div_cnt;
    logic [c_div_w-1:0]   w_div_next;
    logic                 r_pixel_tick;
    logic                 w_h_carry;
    logic                 w_v_carry;
    logic                 w_h_disp;
    logic                 w_v_disp;
    logic                 r_display_on;
    logic                 r_new_line;
    logic                 r_frame_start;
    logic [c_coord_w-1:0] w_next_line;
    logic                 w_line_start;
    fetch_state_t         r_state;
    logic                 r_fetch_req;
    logic [c_coord_w-1:0] r_fetch_line;
    logic                 r_underrun;
    logic                 r_underrun_sticky;

    assign w_clear = !enable;
    assign w_hold  = !rst_n || !enable;

    assign w_div_next = (r_div_cnt == c_div_last) ? '0 : (r_div_cnt + c_div_one);

    // Tick is registered from the next divider value so it is high while div_cnt == CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_div_cnt    <= '0;
            r_pixel_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_next;
            r_pixel_tick <= (w_div_next == c_div_last);
        end
    end

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .WIDTH   (c_coord_w)
    ) u_h_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (w_clear),
        .i_en           (r_pixel_tick),
        .o_count        (pixel_x),
        .o_carry        (w_h_carry),
        .o_display_next (w_h_disp),
        .o_sync_n       (hsync)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .WIDTH   (c_coord_w)
    ) u_v_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (w_clear),
        .i_en           (w_h_carry),
        .o_count        (pixel_y),
        .o_carry        (w_v_carry),
        .o_display_next (w_v_disp),
        .o_sync_n       (vsync)
    );

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_display_on  <= 1'b0;
            r_new_line    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_display_on  <= w_h_disp && w_v_disp;
            r_new_line    <= w_h_carry;
            r_frame_start <= w_v_carry;
        end
    end

    assign w_next_line  = (pixel_y == c_v_last) ? '0 : (pixel_y + c_coord_one);
    assign w_line_start = r_pixel_tick && (pixel_x == c_fetch_x);

    // Ack is checked before the wrap so a same-clock ack completes without underrun.
    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_state           <= IDLE;
            r_fetch_req       <= 1'b0;
            r_fetch_line      <= '0;
            r_underrun        <= 1'b0;
            r_underrun_sticky <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_line_start && (w_next_line < c_v_visible)) begin
                        r_state      <= REQ;
                        r_fetch_req  <= 1'b1;
                        r_fetch_line <= w_next_line;
                    end
                end
                REQ: begin
                    if (fetch.fetch_ack) begin
                        r_state     <= IDLE;
                        r_fetch_req <= 1'b0;
                    end else if (w_h_carry) begin
                        r_state           <= IDLE;
                        r_fetch_req       <= 1'b0;
                        r_underrun        <= 1'b1;
                        r_underrun_sticky <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_tick       = r_pixel_tick;
    assign display_on       = r_display_on;
    assign new_line         = r_new_line;
    assign frame_start      = r_frame_start;
    assign fetch.fetch_req  = r_fetch_req;
    assign fetch.fetch_line = r_fetch_line;
    assign underrun         = r_underrun;
    assign underrun_sticky  = r_underrun_sticky;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_controller
// Purpose  : Bench for the VGA timing controller: a full-size instance for
//            line-level timing and fetch handshakes, and a shrunken-raster
//            instance for whole-frame behaviour and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

    localparam int B_DIV = 3;
    localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VD = 4, B_VF = 1, B_VS = 2, B_VB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] tick, hs, vs, de, x, y, nl, fs, req, line, lv, ur, urs;
    } obs_t;

    // Raster parameters of the two instances: 0 = full size, 1 = shrunken.
    int p_div[2] = '{2, B_DIV};
    int p_hd[2]  = '{640, B_HD};
    int p_hf[2]  = '{16, B_HF};
    int p_hs[2]  = '{96, B_HS};
    int p_hb[2]  = '{48, B_HB};
    int p_vd[2]  = '{480, B_VD};
    int p_vf[2]  = '{10, B_VF};
    int p_vs[2]  = '{2, B_VS};
    int p_vb[2]  = '{33, B_VB};

    int   n_m[2];
    bit   acked_m[2];
    bit   sticky_m[2];
    bit   preq_m[2];
    obs_t exp_m[2];

    logic       rst_a, en_a, tick_a, hs_a, vs_a, de_a, nl_a, fs_a, ur_a, urs_a;
    logic [9:0] x_a, y_a;
    logic       rst_b, en_b, tick_b, hs_b, vs_b, de_b, nl_b, fs_b, ur_b, urs_b;
    logic [9:0] x_b, y_b;

    vga_timing_controller_if if_a ();
    vga_timing_controller_if if_b ();

    vga_timing_controller u_dut_a (
        .clk(clk), .rst_n(rst_a), .enable(en_a), .pixel_tick(tick_a),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a), .pixel_x(x_a), .pixel_y(y_a),
        .new_line(nl_a), .frame_start(fs_a), .fetch(if_a),
        .underrun(ur_a), .underrun_sticky(urs_a)
    );

    vga_timing_controller #(
        .CLK_DIV(B_DIV), .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .enable(en_b), .pixel_tick(tick_b),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b), .pixel_x(x_b), .pixel_y(y_b),
        .new_line(nl_b), .frame_start(fs_b), .fetch(if_b),
        .underrun(ur_b), .underrun_sticky(urs_b)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Raster position is pure arithmetic on the number of clocks since release.
    task automatic model_step(input int id, input logic rs, input logic en, input logic ak);
        obs_t e;
        int   d, ht, vt, p, x, y, nxt;
        bit   bnd;
        d  = p_div[id];
        ht = p_hd[id] + p_hf[id] + p_hs[id] + p_hb[id];
        vt = p_vd[id] + p_vf[id] + p_vs[id] + p_vb[id];
        e  = '{default: 32'd0};
        if (!rs || !en) begin
            n_m[id]      = 0;
            acked_m[id]  = 1'b0;
            sticky_m[id] = 1'b0;
            e.hs = 32'd1;
            e.vs = 32'd1;
            e.lv = 32'd1;
        end else begin
            if (preq_m[id] && ak === 1'b1) acked_m[id] = 1'b1;
            n_m[id]++;
            p   = n_m[id] / d;
            x   = p % ht;
            y   = (p / ht) % vt;
            bnd = ((n_m[id] % d) == 0) && (x == 0);
            e.tick = 32'((n_m[id] % d) == d - 1);
            e.x    = 32'(x);
            e.y    = 32'(y);
            e.hs   = 32'(!(x >= p_hd[id] + p_hf[id] && x < p_hd[id] + p_hf[id] + p_hs[id]));
            e.vs   = 32'(!(y >= p_vd[id] + p_vf[id] && y < p_vd[id] + p_vf[id] + p_vs[id]));
            e.de   = 32'(x < p_hd[id] && y < p_vd[id]);
            e.nl   = 32'(bnd);
            e.fs   = 32'(bnd && y == 0);
            e.ur   = 32'(bnd && preq_m[id] && ak !== 1'b1);
            if (e.ur[0]) sticky_m[id] = 1'b1;
            if (bnd) acked_m[id] = 1'b0;
            nxt    = (y == vt - 1) ? 0 : y + 1;
            e.req  = 32'(x >= p_hd[id] && nxt < p_vd[id] && !acked_m[id]);
            e.line = 32'(nxt);
            e.lv   = e.req;
            e.urs  = 32'(sticky_m[id]);
        end
        preq_m[id] = e.req[0];
        exp_m[id]  = e;
    endtask

    task automatic compare_all(input int id, input obs_t o);
        obs_t e;
        e = exp_m[id];
        cmp($sformatf("u%0d.pixel_tick", id), o.tick, e.tick);
        cmp($sformatf("u%0d.hsync", id), o.hs, e.hs);
        cmp($sformatf("u%0d.vsync", id), o.vs, e.vs);
        cmp($sformatf("u%0d.display_on", id), o.de, e.de);
        cmp($sformatf("u%0d.pixel_x", id), o.x, e.x);
        cmp($sformatf("u%0d.pixel_y", id), o.y, e.y);
        cmp($sformatf("u%0d.new_line", id), o.nl, e.nl);
        cmp($sformatf("u%0d.frame_start", id), o.fs, e.fs);
        cmp($sformatf("u%0d.fetch_req", id), o.req, e.req);
        if (e.lv[0]) cmp($sformatf("u%0d.fetch_line", id), o.line, e.line);
        cmp($sformatf("u%0d.underrun", id), o.ur, e.ur);
        cmp($sformatf("u%0d.underrun_sticky", id), o.urs, e.urs);
    endtask

    // Ack policies: instance a acks after 2 clocks, 5 on y=10, never on y=20;
    // instance b acks after 1 clock, never on y=2.
    int age_a = 0, age_b = 0;
    always @(negedge clk) begin
        int dly_a, dly_b;
        if (if_a.fetch_req === 1'b1) age_a++; else age_a = 0;
        if (if_b.fetch_req === 1'b1) age_b++; else age_b = 0;
        dly_a = (y_a == 10'd10) ? 5 : ((y_a == 10'd20) ? -1 : 2);
        dly_b = (y_b == 10'd2) ? -1 : 1;
        if_a.fetch_ack = (if_a.fetch_req === 1'b1) && (dly_a >= 0) && (age_a > dly_a);
        if_b.fetch_ack = (if_b.fetch_req === 1'b1) && (dly_b >= 0) && (age_b > dly_b);
    end

    int a_hs_low = 0, a_de_cnt = 0, a_first_hs_x = -1, a_nl_last = 0, a_nl_int = 0;
    int a_ur_cnt = 0, a_line10 = -1;
    int a_req_cnt[32];
    int b_fs_cnt = 0, b_fs1 = 0, b_fs2 = 0, b_vs_low = 0, b_req_invis = 0, b_line8 = -1;

    always @(posedge clk) begin : p_mon_a
        logic rs, en, ak;
        obs_t o;
        rs = rst_a; en = en_a; ak = if_a.fetch_ack;
        #1;
        model_step(0, rs, en, ak);
        o = '{tick: 32'(tick_a), hs: 32'(hs_a), vs: 32'(vs_a), de: 32'(de_a),
              x: 32'(x_a), y: 32'(y_a), nl: 32'(nl_a), fs: 32'(fs_a),
              req: 32'(if_a.fetch_req), line: 32'(if_a.fetch_line), lv: 32'd0,
              ur: 32'(ur_a), urs: 32'(urs_a)};
        compare_all(0, o);
        if (rs === 1'b1 && en === 1'b1) begin
            if (n_m[0] == 1) begin
                cmp("a.tick_at_cycle1", 32'(tick_a), 32'd1);
                cmp("a.x_at_cycle1", 32'(x_a), 32'd0);
            end
            if (n_m[0] == 2) cmp("a.x_at_cycle2", 32'(x_a), 32'd1);
            if (y_a == 10'd1 && !hs_a) begin
                if (a_first_hs_x < 0) a_first_hs_x = int'(x_a);
                a_hs_low++;
            end
            if (y_a == 10'd1 && de_a) a_de_cnt++;
            if (nl_a) begin
                if (a_nl_last > 0 && a_nl_int == 0) a_nl_int = n_m[0] - a_nl_last;
                a_nl_last = n_m[0];
            end
            if (if_a.fetch_req && y_a < 10'd32) a_req_cnt[y_a[4:0]]++;
            if (if_a.fetch_req && y_a == 10'd10) a_line10 = int'(if_a.fetch_line);
            if (ur_a) a_ur_cnt++;
        end
    end

    always @(posedge clk) begin : p_mon_b
        logic rs, en, ak;
        obs_t o;
        rs = rst_b; en = en_b; ak = if_b.fetch_ack;
        #1;
        model_step(1, rs, en, ak);
        o = '{tick: 32'(tick_b), hs: 32'(hs_b), vs: 32'(vs_b), de: 32'(de_b),
              x: 32'(x_b), y: 32'(y_b), nl: 32'(nl_b), fs: 32'(fs_b),
              req: 32'(if_b.fetch_req), line: 32'(if_b.fetch_line), lv: 32'd0,
              ur: 32'(ur_b), urs: 32'(urs_b)};
        compare_all(1, o);
        if (rs === 1'b1 && en === 1'b1) begin
            if (fs_b) begin
                b_fs_cnt++;
                if (b_fs_cnt == 1) b_fs1 = n_m[1];
                if (b_fs_cnt == 2) b_fs2 = n_m[1];
            end
            if (b_fs_cnt == 1 && !vs_b) b_vs_low++;
            if (if_b.fetch_req && y_b >= 10'd3 && y_b <= 10'd7) b_req_invis++;
            if (if_b.fetch_req && y_b == 10'd8) b_line8 = int'(if_b.fetch_line);
        end
    end

    task automatic run_a();
        int guard;
        rst_a = 1'b0; en_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        cmp("a.reset_hsync", 32'(hs_a), 32'd1);
        cmp("a.reset_vsync", 32'(vs_a), 32'd1);
        cmp("a.reset_display_on", 32'(de_a), 32'd0);
        cmp("a.reset_fetch_req", 32'(if_a.fetch_req), 32'd0);
        guard = 0;
        while (y_a != 10'd22 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        cmp("a.reached_line22", 32'(guard < 40000), 32'd1);
        cmp("a.hsync_low_clocks_y1", 32'(a_hs_low), 32'd192);
        cmp("a.hsync_first_x_y1", 32'(a_first_hs_x), 32'd656);
        cmp("a.display_clocks_y1", 32'(a_de_cnt), 32'd1280);
        cmp("a.new_line_interval", 32'(a_nl_int), 32'd1600);
        cmp("a.req_clocks_y10", 32'(a_req_cnt[10]), 32'd6);
        cmp("a.fetch_line_y10", 32'(a_line10), 32'd11);
        cmp("a.req_clocks_y20", 32'(a_req_cnt[20]), 32'd320);
        cmp("a.req_clocks_y21", 32'(a_req_cnt[21]), 32'd3);
        cmp("a.underrun_pulses", 32'(a_ur_cnt), 32'd1);
        cmp("a.underrun_sticky", 32'(urs_a), 32'd1);
    endtask

    task automatic run_b();
        int guard;
        rst_b = 1'b0; en_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        guard = 0;
        while (b_fs_cnt < 2 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        cmp("b.two_frames_seen", 32'(guard < 2000), 32'd1);
        cmp("b.frame_interval", 32'(b_fs2 - b_fs1), 32'd405);
        cmp("b.vsync_low_clocks", 32'(b_vs_low), 32'd90);
        cmp("b.fetch_line_y8", 32'(b_line8), 32'd0);
        guard = 0;
        while (!(y_b == 10'd2 && x_b == 10'd12 && if_b.fetch_req) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        cmp("b.req_window_found", 32'(guard < 2000), 32'd1);
        cmp("b.sticky_before_reset", 32'(urs_b), 32'd1);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        cmp("b.reset_fetch_req", 32'(if_b.fetch_req), 32'd0);
        cmp("b.reset_underrun", 32'(ur_b), 32'd0);
        cmp("b.reset_sticky", 32'(urs_b), 32'd0);
        cmp("b.reset_xy", 32'({x_b, y_b}), 32'd0);
        repeat (100) @(negedge clk);
        en_b = 1'b0;
        repeat (3) @(negedge clk);
        en_b = 1'b1;
        repeat (150) @(negedge clk);
        cmp("b.no_req_invisible_lines", 32'(b_req_invis), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) a_req_cnt[i] = 0;
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
